// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
//   Per-run sequencer and attractor detector for the GNR node array.
//   It takes one initial state and loads it into every node. It then steps a
//   slow (s0) and a fast (s1) trajectory until the two meet or the step budget
//   runs out, and returns the result through a valid/ready port.
//
//   Optional feature: define GNR_PERIOD_EN to measure the attractor period
//   after a meet. Without it, res_period_o is tied to 0.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   init_valid_i/ready_o  initial-state handshake (init_data_i, max_steps_i)
//   reset_nos_o           one-cycle node load strobe
//   init_state_o          state broadcast to the nodes
//   start_s0_o/start_s1_o slow / fast trajectory step enables
//   s0_vec_i, s1_vec_i    concatenated node outputs
//   res_valid_o/ready_i   result handshake
//   res_init_o, res_state_o, res_steps_o, res_period_o, res_timeout_o
//   busy_o                controller not idle
//
// state  | meaning
// IDLE   | waiting for an initial state
// LOAD   | node load strobe
// RUN    | tortoise-hare search
// PERIOD | fast trajectory only, measuring cycle length (GNR_PERIOD_EN)
// DONE   | result held until consumed

module gnr_attractor_ctrl #(
  parameter int N_NODES = 188,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_valid_i,
  output logic               init_ready_o,
  input  logic [N_NODES-1:0] init_data_i,
  input  logic [CNT_W-1:0]   max_steps_i,
  output logic               reset_nos_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               start_s0_o,
  output logic               start_s1_o,
  input  logic [N_NODES-1:0] s0_vec_i,
  input  logic [N_NODES-1:0] s1_vec_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [N_NODES-1:0] res_init_o,
  output logic [N_NODES-1:0] res_state_o,
  output logic [CNT_W-1:0]   res_steps_o,
  output logic [CNT_W-1:0]   res_period_o,
  output logic               res_timeout_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3
`ifdef GNR_PERIOD_EN
    ,S_PERIOD = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [N_NODES-1:0] init_q, init_d;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   res_steps_q, res_steps_d;
  logic               res_timeout_q, res_timeout_d;
  logic               meet, run_timeout;
`ifdef GNR_PERIOD_EN
  logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]   res_period_q, res_period_d;
  logic               per_found, per_timeout;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Step 0 compares the freshly loaded state with itself, so it never counts.
  assign meet        = (step_cnt_q != '0) && (s0_vec_i == s1_vec_i);
  assign run_timeout = !meet && (step_cnt_q == max_q);
`ifdef GNR_PERIOD_EN
  assign per_found   = (period_cnt_q != '0) && (s1_vec_i == res_state_q);
  assign per_timeout = !per_found && (period_cnt_q == max_q);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      init_q        <= '0;
      max_q         <= '0;
      step_cnt_q    <= '0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
`ifdef GNR_PERIOD_EN
      period_cnt_q  <= '0;
      res_period_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_q        <= init_d;
      max_q         <= max_d;
      step_cnt_q    <= step_cnt_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
`ifdef GNR_PERIOD_EN
      period_cnt_q  <= period_cnt_d;
      res_period_q  <= res_period_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    init_d        = init_q;
    max_d         = max_q;
    step_cnt_d    = step_cnt_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;
`ifdef GNR_PERIOD_EN
    period_cnt_d  = period_cnt_q;
    res_period_d  = res_period_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (init_valid_i) begin
          init_d        = init_data_i;
          max_d         = max_steps_i;
          step_cnt_d    = '0;
          // Results of the previous run are dropped so a timeout flag cannot leak.
          res_state_d   = '0;
          res_steps_d   = '0;
          res_timeout_d = 1'b0;
`ifdef GNR_PERIOD_EN
          res_period_d  = '0;
`endif
          state_d       = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (meet) begin
          res_state_d = s1_vec_i;
          res_steps_d = step_cnt_q;
`ifdef GNR_PERIOD_EN
          period_cnt_d = '0;
          state_d      = S_PERIOD;
`else
          state_d      = S_DONE;
`endif
        end else if (run_timeout) begin
          res_timeout_d = 1'b1;
          res_steps_d   = step_cnt_q;
          state_d       = S_DONE;
        end else begin
          step_cnt_d = sat_inc(step_cnt_q);
        end
      end
`ifdef GNR_PERIOD_EN
      S_PERIOD: begin
        if (per_found) begin
          res_period_d = period_cnt_q;
          state_d      = S_DONE;
        end else if (per_timeout) begin
          res_timeout_d = 1'b1;
          res_period_d  = '0;
          state_d       = S_DONE;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end
`endif
      S_DONE: if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by rst_i so nothing pulses in the reset cycle itself.
  always_comb begin
    reset_nos_o = 1'b0;
    start_s0_o  = 1'b0;
    start_s1_o  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        S_LOAD: reset_nos_o = 1'b1;
        S_RUN: begin
          start_s0_o = !meet && !run_timeout;
          start_s1_o = !meet && !run_timeout;
        end
`ifdef GNR_PERIOD_EN
        S_PERIOD: start_s1_o = !per_found && !per_timeout;
`endif
        default: ;
      endcase
    end
    init_ready_o  = (state_q == S_IDLE);
    busy_o        = (state_q != S_IDLE);
    res_valid_o   = (state_q == S_DONE);
    init_state_o  = (state_q != S_IDLE) ? init_q : '0;
    res_init_o    = init_q;
    res_state_o   = res_state_q;
    res_steps_o   = res_steps_q;
    res_timeout_o = res_timeout_q;
`ifdef GNR_PERIOD_EN
    res_period_o  = res_period_q;
`else
    res_period_o  = '0;
`endif
  end

endmodule
